mul_arbiter: RTL and testbench

- Round-robin controller that shares one N-bit unsigned multiply unit among R requesters.
- Accepts one operand pair at a time through a per-requester valid/ready handshake.
- Drives the multiply unit from registered operands and captures its result and flags.
- Returns the result tagged with the requester ID through a valid/ready response port.
- Sits between the lane/issue logic and the shared multiplier instance.

---
 rtl/mul_arb_pkg.sv | 16 +
 rtl/mul_arbiter_if.sv | 52 +++++
 rtl/mul_arbiter_rr_arbiter.sv | 41 ++++
 rtl/mul_arbiter.sv | 117 +++++++++++
 tb/tb_mul_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and helpers for the mul_arbiter block.
//   state_t : controller FSM states (IDLE, EXEC, HOLD)
//   idw_of  : requester-ID width for a given requester count (min 1 bit)
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int idw_of(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: bundles the requester, response and multiply-unit buses
// of mul_arbiter.
//   req_*  : per-requester operand handshake (R lanes, one-hot ready)
//   resp_* : tagged result handshake towards the consumer
//   mul_*  : operands out to / result and flags back from the multiply unit
// Handshake rule for both req and resp: a transfer happens on a rising edge
// where valid & ready are both high; the producer holds valid and payload
// stable until that edge, and valid never depends on ready.
interface mul_arbiter_if #(
    parameter int N = 32,
    parameter int R = 4
) ();
    import mul_arb_pkg::*;
    localparam int IDW = idw_of(R);

    logic [R-1:0]          req_valid;
    logic [R-1:0][N-1:0]   req_a;
    logic [R-1:0][N-1:0]   req_b;
    logic [R-1:0]          req_ready;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [N-1:0]          resp_c;
    logic                  resp_cout;
    logic                  resp_zero;
    logic                  resp_overflow;

    logic [N-1:0]          mul_a;
    logic [N-1:0]          mul_b;
    logic [N-1:0]          mul_c;
    logic                  mul_cout;
    logic                  mul_zero;
    logic                  mul_overflow;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
               mul_c, mul_cout, mul_zero, mul_overflow,
        output req_ready, resp_valid, resp_id, resp_c, resp_cout,
               resp_zero, resp_overflow, mul_a, mul_b
    );

    // Requester / consumer / multiply-unit side
    modport master (
        output req_valid, req_a, req_b, resp_ready,
               mul_c, mul_cout, mul_zero, mul_overflow,
        input  req_ready, resp_valid, resp_id, resp_c, resp_cout,
               resp_zero, resp_overflow, mul_a, mul_b
    );

endinterface

// File: rtl/mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   i_req          : request vector
//   i_ptr          : highest-priority index this cycle
//   o_grant_onehot : one-hot grant (zero when nothing requests)
//   o_grant_idx    : index of the granted requester
//   o_any          : at least one request present
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter  int R   = 4,
    localparam int IDW = idw_of(R)
) (
    input  logic [R-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [R-1:0]   o_grant_onehot,
    output logic [IDW-1:0] o_grant_idx,
    output logic           o_any
);

    // Index k steps after the pointer, wrapped modulo R.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return IDW'((s >= R) ? s - R : s);
    endfunction

    always_comb begin
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        o_any          = 1'b0;
        // First requester found scanning ptr, ptr+1, ... wins.
        for (int k = 0; k < R; k++) begin
            if (!o_any && i_req[wrap_idx(i_ptr, k)]) begin
                o_any                               = 1'b1;
                o_grant_idx                         = wrap_idx(i_ptr, k);
                o_grant_onehot[wrap_idx(i_ptr, k)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one N-bit multiply unit among R requesters.
// One operation in flight: IDLE (arbitrate) -> EXEC (unit sees registered
// operands, result captured) -> HOLD (tagged response held until taken).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   mul_if      : requester / response / multiply-unit buses (slave side)
//   o_dbg_state : current FSM state, for observation only
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N = 32,
    parameter int R = 4
) (
    input  logic          clk,
    input  logic          rst,
    mul_arbiter_if.slave  mul_if,
    output state_t        o_dbg_state
);

    localparam int IDW = idw_of(R);

    state_t         r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [N-1:0]   r_op_a;
    logic [N-1:0]   r_op_b;
    logic [IDW-1:0] r_op_id;
    logic [IDW-1:0] r_resp_id;
    logic [N-1:0]   r_res_c;
    logic           r_res_cout;
    logic           r_res_zero;
    logic           r_res_ovf;
    logic           r_resp_valid;

    state_t         w_next_state;
    logic           w_arb_en;
    logic           w_accept;
    logic [R-1:0]   w_grant_onehot;
    logic [IDW-1:0] w_grant_idx;
    logic           w_any;

    rr_arbiter #(.R(R)) u_rr (
        .i_req          (mul_if.req_valid),
        .i_ptr          (r_rr_ptr),
        .o_grant_onehot (w_grant_onehot),
        .o_grant_idx    (w_grant_idx),
        .o_any          (w_any)
    );

    // Arbitration is open in IDLE, and in HOLD on the cycle the response
    // is consumed so a waiting request is taken back-to-back.
    always_comb begin
        w_next_state = r_state;
        w_arb_en     = 1'b0;
        case (r_state)
            IDLE: begin
                w_arb_en = 1'b1;
                if (w_any) w_next_state = EXEC;
            end
            EXEC: w_next_state = HOLD;
            HOLD: begin
                if (mul_if.resp_ready) begin
                    w_arb_en     = 1'b1;
                    w_next_state = w_any ? EXEC : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        w_accept = w_arb_en && w_any && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_id      <= '0;
            r_resp_id    <= '0;
            r_res_c      <= '0;
            r_res_cout   <= 1'b0;
            r_res_zero   <= 1'b0;
            r_res_ovf    <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op_a   <= mul_if.req_a[w_grant_idx];
                r_op_b   <= mul_if.req_b[w_grant_idx];
                r_op_id  <= w_grant_idx;
                r_rr_ptr <= (w_grant_idx == IDW'(R - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (r_state == EXEC) begin
                r_res_c      <= mul_if.mul_c;
                r_res_cout   <= mul_if.mul_cout;
                r_res_zero   <= mul_if.mul_zero;
                r_res_ovf    <= mul_if.mul_overflow;
                r_resp_id    <= r_op_id;
                r_resp_valid <= 1'b1;
            end else if (r_state == HOLD && mul_if.resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    // Handshake outputs are forced low while reset is asserted.
    assign mul_if.req_ready     = (w_arb_en && !rst) ? w_grant_onehot : '0;
    assign mul_if.resp_valid    = r_resp_valid && !rst;
    assign mul_if.resp_id       = r_resp_id;
    assign mul_if.resp_c        = r_res_c;
    assign mul_if.resp_cout     = r_res_cout;
    assign mul_if.resp_zero     = r_res_zero;
    assign mul_if.resp_overflow = r_res_ovf;
    assign mul_if.mul_a         = r_op_a;
    assign mul_if.mul_b         = r_op_b;
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed scoreboard bench for mul_arbiter (N=32, R=4)
// with a bit-exact behavioural multiply unit.
module tb_mul_arbiter;
    import mul_arb_pkg::*;

    localparam int N   = 32;
    localparam int R   = 4;
    localparam int IDW = 2;
    localparam int W   = IDW + N + 3;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    mul_arbiter_if #(.N(N), .R(R)) bus ();

    mul_arbiter #(.N(N), .R(R)) dut (
        .clk         (clk),
        .rst         (rst),
        .mul_if      (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference multiply unit ----------------
    logic [2*N-1:0] prod;
    always_comb begin
        prod             = 64'(bus.mul_a) * 64'(bus.mul_b);
        bus.mul_c        = prod[N-1:0];
        bus.mul_cout     = prod[N];
        bus.mul_overflow = prod[N+1];
        bus.mul_zero     = (bus.mul_a == '0) || (bus.mul_b == '0);
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [W-1:0] pack_resp(input logic [IDW-1:0] id, input logic [N-1:0] c,
                                               input logic cout, input logic zero, input logic ovf);
        return {id, c, cout, zero, ovf};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares on every completed response handshake.
    logic [W-1:0] act_resp;
    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            act_resp = {bus.resp_id, bus.resp_c, bus.resp_cout, bus.resp_zero, bus.resp_overflow};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got 0x%0h with nothing expected", act_resp);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (act_resp !== e) begin
                    n_fail++;
                    $display("FAIL resp: got id=%0d c=0x%0h cout=%0b zero=%0b ovf=%0b expected id=%0d c=0x%0h cout=%0b zero=%0b ovf=%0b",
                             act_resp[W-1 -: IDW], act_resp[N+2:3], act_resp[2], act_resp[1], act_resp[0],
                             e[W-1 -: IDW], e[N+2:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.req_a[i] = a;
        bus.req_b[i] = b;
    endtask

    // Round-robin table: operands and hand-computed responses per requester.
    logic [N-1:0] rr_a   [4] = '{32'd7,  32'd100,   32'h0001_0000, 32'h8000_0000};
    logic [N-1:0] rr_b   [4] = '{32'd6,  32'd100,   32'h0001_0000, 32'd4};
    logic [N-1:0] rr_c   [4] = '{32'd42, 32'd10000, 32'd0,         32'd0};
    logic         rr_cout[4] = '{1'b0,   1'b0,      1'b1,          1'b0};
    logic         rr_ovf [4] = '{1'b0,   1'b0,      1'b0,          1'b1};

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("reset_req_ready",  64'(bus.req_ready),  64'd0);
        check("reset_state",      64'(dbg_state),      64'(IDLE));
        check("reset_resp_c",     64'(bus.resp_c),     64'd0);
        check("reset_resp_id",    64'(bus.resp_id),    64'd0);
        check("reset_mul_a",      64'(bus.mul_a),      64'd0);

        // Reset while holding an unconsumed response: it must vanish.
        step();
        rst           = 1'b0;
        bus.req_valid = 4'b0010;
        set_req(1, 32'd5, 32'd5);
        @(negedge clk);
        check("hold_rst_grant", 64'(bus.req_ready), 64'h2);
        step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        check("hold_rst_valid_before", 64'(bus.resp_valid), 64'd1);
        check("hold_rst_state",        64'(dbg_state),      64'(HOLD));
        step();
        rst           = 1'b1;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_req_ready",  64'(bus.req_ready),  64'd0);

        // All requesters valid after reset: grants 0,1,2,3,0 every 2 cycles.
        step();
        rst            = 1'b0;
        bus.resp_ready = 1'b1;
        bus.req_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i]);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step();
            @(negedge clk);
            if (k == 0) check("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
            if (k % 2 == 0) begin
                int g;
                g = (k / 2) % 4;
                check($sformatf("rr_grant_k%0d", k), 64'(bus.req_ready), 64'(1 << g));
                exp_q.push_back(pack_resp(IDW'(g), rr_c[g], rr_cout[g], 1'b0, rr_ovf[g]));
            end else begin
                check($sformatf("rr_idle_k%0d", k), 64'(bus.req_ready), 64'd0);
            end
        end
        step();
        bus.req_valid = '0;
        step();
        step();

        // Back-pressure: requester 3 (rr_ptr=1), response held 5 cycles.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b1000;
        set_req(3, 32'd9, 32'd9);
        @(negedge clk);
        check("bp_grant3", 64'(bus.req_ready), 64'h8);
        exp_q.push_back(pack_resp(2'd3, 32'd81, 1'b0, 1'b0, 1'b0));
        step();
        bus.req_valid = 4'b0010;
        set_req(1, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        check("bp_exec_no_ready", 64'(bus.req_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            check($sformatf("bp_hold_valid_%0d", k), 64'(bus.resp_valid), 64'd1);
            check($sformatf("bp_hold_c_%0d", k),     64'(bus.resp_c),     64'd81);
            check($sformatf("bp_hold_id_%0d", k),    64'(bus.resp_id),    64'd3);
            check($sformatf("bp_hold_ready_%0d", k), 64'(bus.req_ready),  64'd0);
        end
        step();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_b2b_grant1", 64'(bus.req_ready), 64'h2);
        exp_q.push_back(pack_resp(2'd1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0));
        step();
        bus.req_valid = '0;
        step();
        step();

        // Single request from id 2 (rr_ptr=2): 3*5 with latency 2.
        bus.req_valid = 4'b0100;
        set_req(2, 32'd3, 32'd5);
        @(negedge clk);
        check("single_grant2", 64'(bus.req_ready), 64'h4);
        exp_q.push_back(pack_resp(2'd2, 32'd15, 1'b0, 1'b0, 1'b0));
        step();
        bus.req_valid = '0;
        @(negedge clk);
        check("single_mul_a",      64'(bus.mul_a),      64'd3);
        check("single_mul_b",      64'(bus.mul_b),      64'd5);
        check("single_t1_valid",   64'(bus.resp_valid), 64'd0);
        step();
        @(negedge clk);
        check("single_t2_valid",   64'(bus.resp_valid), 64'd1);
        step();

        // Zero operand from requester 0 (rr_ptr=3 wraps to 0).
        bus.req_valid = 4'b0001;
        set_req(0, 32'd0, 32'd7);
        @(negedge clk);
        check("zero_grant0", 64'(bus.req_ready), 64'h1);
        exp_q.push_back(pack_resp(2'd0, 32'd0, 1'b0, 1'b1, 1'b0));
        step();
        bus.req_valid = '0;

        // Drain with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        step();
        @(negedge clk);
        check("final_state_idle", 64'(dbg_state), 64'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
